// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// MULT/MULTU run as shift-add, DIV/DIVU as restoring divide, WIDTH iterations each.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    // state | meaning
    // IDLE  | waiting for issue; MTHI/MTLO serviced here
    // CALC  | one shift-add or trial-subtract step per cycle
    // FIX   | sign correction and HI/LO commit
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               is_div_q, is_div_d;
    logic               neg_x_q, neg_x_d;
    logic               neg_y_q, neg_y_d;
    logic               y_zero_q, y_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               sgn_op;
    logic [WIDTH-1:0]   mag_x, mag_y;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    assign sgn_op = ~op[0];
    assign mag_x  = (sgn_op && X[WIDTH-1]) ? -X : X;
    assign mag_y  = (sgn_op && Y[WIDTH-1]) ? -Y : Y;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        x_d      = x_q;
        is_div_d = is_div_q;
        neg_x_d  = neg_x_q;
        neg_y_d  = neg_y_q;
        y_zero_d = y_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        prod     = '0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        state_d  = CALC;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        neg_x_d  = sgn_op & X[WIDTH-1];
                        neg_y_d  = sgn_op & Y[WIDTH-1];
                        x_d      = X;
                        y_zero_d = (Y == '0);
                        if (op[1]) begin
                            acc_d = {{WIDTH{1'b0}}, mag_x};
                            dvs_d = mag_y;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, mag_y};
                            dvs_d = mag_x;
                        end
                    end else if (!op[1]) begin
                        if (op[0]) lo_d = X;
                        else       hi_d = X;
                    end
                end
            end
            CALC: begin
                // acc holds {partial/remainder, multiplier/quotient} in both modes
                if (is_div_q) begin
                    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
                    diff    = shifted - {1'b0, dvs_q};
                    if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                            (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                if (cancel) state_d = IDLE;
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        if (y_zero_q) begin
                            lo_d = '1;
                            hi_d = x_q;
                        end else begin
                            lo_d = (neg_x_q ^ neg_y_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                            hi_d = neg_x_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        prod = (neg_x_q ^ neg_y_q) ? -acc_q : acc_q;
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            x_q      <= '0;
            is_div_q <= 1'b0;
            neg_x_q  <= 1'b0;
            neg_y_q  <= 1'b0;
            y_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            x_q      <= x_d;
            is_div_q <= is_div_d;
            neg_x_q  <= neg_x_d;
            neg_y_q  <= neg_y_d;
            y_zero_q <= y_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer owning the architectural HI/LO register pair of the MIPS core. Performs MULT/MULTU as a 32-step shift-add and DIV/DIVU as a 32-step restoring divide, so the single-cycle ALU does not need a combinational multiplier or divider. Services MTHI/MTLO writes. Raises `busy` so the pipeline control stalls MFHI/MFLO and further mult/div issue until the result has been committed.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width; the iteration count equals WIDTH.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  issue request, sampled on a rising edge.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x ignored.
- `X`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `Y`  in  WIDTH  rt operand (divisor / multiplier).
- `cancel`  in  1  exception flush; aborts any in-flight operation.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by a mult/div.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, CALC, FIX. `busy` = (state != IDLE).
- **IDLE, start with op 000–011.** Latch the operands, the op and the sign flags. Load magnitudes: for signed ops, negate an operand if it is negative. For unsigned ops, use the operands as-is. Clear the iteration counter and go to CALC.
- **IDLE, start with MTHI/MTLO.** Write X to HI or LO at that edge. State stays IDLE. `busy` stays low and `done` is not pulsed.
- **IDLE, start with op 11x.** No effect.
- **CALC.** One iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: 2·WIDTH-bit accumulator. Add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: shift the remainder left by one bit and trial-subtract the divisor. Keep the result and set the quotient bit only if the subtraction does not underflow.
- **FIX.** Apply sign correction and write HI/LO, then go to IDLE.
  - Signed multiply: negate the 2·WIDTH-bit product when the operand signs differ.
  - Signed divide: negate the quotient when the signs differ. The remainder takes the dividend's sign.
  - Results: multiply gives {HI,LO} = product. Divide gives LO = quotient and HI = remainder.
- **Divide by zero (Y == 0), DIV or DIVU.** Full latency still applies. Sign correction is skipped: LO = all ones, HI = X as latched.
- **Most-negative operand.** 0x80000000 has magnitude 0x80000000, treated as unsigned. DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no trap).
- **start while busy.** Ignored. The operands and op of the operation in flight are not disturbed.
- **cancel.** Next edge forces IDLE. HI/LO are unchanged and no `done` is produced.
  - cancel in FIX: HI/LO are not written.
  - cancel together with start in IDLE: cancel wins and nothing is issued, including MTHI/MTLO.
- **Reset.** `rst_n` low at any edge, including mid-operation, forces IDLE, HI = 0, LO = 0, `busy` = 0, `done` = 0. Reset takes priority over cancel and start.

## Timing
- Reset values of all outputs are 0.
- Mult/div issue: start sampled at edge E0.
  - `busy` is high from after E0 until after edge E0+WIDTH+1, which is the FIX edge.
  - HI/LO and `done` = 1 are visible after the FIX edge. `done` falls after the next edge.
  - Total latency is WIDTH+1 = 33 cycles from issue to result.
- Back-to-back mult/div issue: a new start is accepted in the same cycle that `done` is high, because the state is IDLE then.
- MTHI/MTLO: HI/LO update is visible after the issue edge (1 cycle).
- `busy`, `done`, HI and LO are all registered outputs, with no combinational path from the inputs.

## Test plan
- Reset check: after reset, HI = LO = 0, `busy` = 0, `done` = 0. Issue MTHI 0x12345678 → HI = 0x12345678 one cycle later and `busy` never rises.
- MULT X = 0xFFFFFFFD (−3), Y = 7 → after 33 cycles `done` pulses once, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. `busy` is high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Issue a second start on the `done` cycle → it is accepted.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100.
- DIVU 100 / 7 with a start (MULT 5, 5) asserted at cycle 10 → the second start is ignored and the result is LO = 14, HI = 2.
- MULT 5, 5 with cancel at cycle 20 → `busy` drops next cycle and HI/LO keep their prior values with no `done`. Repeat with `rst_n` low at cycle 20 → HI = LO = 0.
